// File: rtl/netwalk_tcam_programmer.sv
// Command-driven TCAM programmer: tracks entry occupancy, allocates the lowest free entry
// for adds, and drives the shared TCAM programming bus with one-hot single-cycle pulses.
module netwalk_tcam_programmer #(
    parameter int DPL_MATCH_FIELD_WIDTH = 356,
    parameter int TCAM_ADDR_WIDTH       = 8,
    parameter int TCAM_DEPTH            = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [TCAM_ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [DPL_MATCH_FIELD_WIDTH-1:0] cmd_data,
    input  logic [DPL_MATCH_FIELD_WIDTH-1:0] cmd_mask,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [1:0]                       rsp_status,
    output logic [TCAM_ADDR_WIDTH-1:0]       rsp_addr,
    output logic [TCAM_ADDR_WIDTH:0]         occupancy,
    output logic                             table_full,
    output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_data,
    output logic [DPL_MATCH_FIELD_WIDTH-1:0] tcam_program_mask,
    output logic [TCAM_ADDR_WIDTH-1:0]       tcam_program_addr,
    output logic [TCAM_DEPTH-1:0]            tcam_unit_sel,
    output logic                             tcam_program_enable,
    output logic                             tcam_delete_enable
);
    localparam int AW = TCAM_ADDR_WIDTH;
    localparam int DW = DPL_MATCH_FIELD_WIDTH;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_FULL      = 2'b01;
    localparam logic [1:0] ST_BAD_ADDR  = 2'b10;
    localparam logic [1:0] ST_NOT_FOUND = 2'b11;

    localparam logic [TCAM_DEPTH-1:0] ONE_BIT = {{(TCAM_DEPTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, PROG, CLEAR, RESP} state_t;

    state_t                state_reg, state_next;
    logic                  live_reg;
    logic [1:0]            op_reg, op_next;
    logic [AW-1:0]         target_reg, target_next;
    logic [DW-1:0]         data_reg, data_next;
    logic [DW-1:0]         mask_reg, mask_next;
    logic [1:0]            status_reg, status_next;
    logic [AW-1:0]         rsp_addr_reg, rsp_addr_next;
    logic [AW-1:0]         clr_cnt_reg, clr_cnt_next;
    logic [TCAM_DEPTH-1:0] valid_reg, valid_next;
    logic [AW:0]           occ_reg, occ_next;

    logic                  free_found;
    logic [AW-1:0]         free_idx;
    logic                  addr_ok;
    logic                  addr_hit;
    logic                  prog_active;
    logic                  write_pulse;
    logic [AW-1:0]         sel_addr;
    logic                  sel_hit;

    // Lowest free entry: scan downward so the last assignment wins with the smallest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = TCAM_DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
        end
    end

    assign addr_ok  = ({1'b0, cmd_addr} < (AW+1)'(TCAM_DEPTH));
    assign addr_hit = |(valid_reg & (ONE_BIT << cmd_addr));

    assign prog_active = (state_reg == PROG) || (state_reg == CLEAR);
    assign write_pulse = (state_reg == PROG) && (op_reg != OP_DELETE);
    assign sel_addr    = (state_reg == PROG) ? target_reg : clr_cnt_reg;

    generate
        for (genvar gi = 0; gi < TCAM_DEPTH; gi++) begin : g_sel
            assign tcam_unit_sel[gi] = prog_active && (sel_addr == AW'(gi));
        end
    endgenerate

    assign tcam_program_enable = prog_active;
    assign tcam_delete_enable  = (state_reg == CLEAR) || ((state_reg == PROG) && (op_reg == OP_DELETE));
    assign tcam_program_addr   = prog_active ? sel_addr : '0;
    assign tcam_program_data   = write_pulse ? data_reg : '0;
    assign tcam_program_mask   = write_pulse ? mask_reg : '0;

    assign rsp_valid  = (state_reg == RESP);
    assign rsp_status = status_reg;
    assign rsp_addr   = rsp_addr_reg;
    assign occupancy  = occ_reg;
    assign table_full = (occ_reg == (AW+1)'(TCAM_DEPTH));

    // The one-hot select doubles as the bitmap update mask for both writes and deletes.
    assign sel_hit = |(valid_reg & tcam_unit_sel);

    always_comb begin
        valid_next = valid_reg;
        occ_next   = occ_reg;
        if (prog_active) begin
            if (tcam_delete_enable) begin
                valid_next = valid_reg & ~tcam_unit_sel;
                if (sel_hit) occ_next = occ_reg - (AW+1)'(1);
            end else begin
                valid_next = valid_reg | tcam_unit_sel;
                if (!sel_hit) occ_next = occ_reg + (AW+1)'(1);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        target_next   = target_reg;
        data_next     = data_reg;
        mask_next     = mask_reg;
        status_next   = status_reg;
        rsp_addr_next = rsp_addr_reg;
        clr_cnt_next  = clr_cnt_reg;
        cmd_ready     = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = live_reg;
                if (live_reg && cmd_valid) begin
                    op_next       = cmd_op;
                    data_next     = cmd_data;
                    mask_next     = cmd_mask;
                    status_next   = ST_OK;
                    rsp_addr_next = '0;
                    case (cmd_op)
                        OP_ADD: begin
                            if (free_found) begin
                                target_next = free_idx;
                                state_next  = PROG;
                            end else begin
                                status_next = ST_FULL;
                                state_next  = RESP;
                            end
                        end
                        OP_WRITE: begin
                            if (addr_ok) begin
                                target_next = cmd_addr;
                                state_next  = PROG;
                            end else begin
                                status_next = ST_BAD_ADDR;
                                state_next  = RESP;
                            end
                        end
                        OP_DELETE: begin
                            if (!addr_ok) begin
                                status_next = ST_BAD_ADDR;
                                state_next  = RESP;
                            end else if (!addr_hit) begin
                                status_next = ST_NOT_FOUND;
                                state_next  = RESP;
                            end else begin
                                target_next = cmd_addr;
                                state_next  = PROG;
                            end
                        end
                        default: begin
                            clr_cnt_next = '0;
                            state_next   = CLEAR;
                        end
                    endcase
                end
            end
            PROG: begin
                status_next   = ST_OK;
                rsp_addr_next = target_reg;
                state_next    = RESP;
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + AW'(1);
                if (clr_cnt_reg == AW'(TCAM_DEPTH - 1)) begin
                    status_next   = ST_OK;
                    rsp_addr_next = '0;
                    state_next    = RESP;
                end
            end
            default: begin
                if (rsp_ready) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            live_reg     <= 1'b0;
            op_reg       <= '0;
            target_reg   <= '0;
            data_reg     <= '0;
            mask_reg     <= '0;
            status_reg   <= '0;
            rsp_addr_reg <= '0;
            clr_cnt_reg  <= '0;
            valid_reg    <= '0;
            occ_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            live_reg     <= 1'b1;
            op_reg       <= op_next;
            target_reg   <= target_next;
            data_reg     <= data_next;
            mask_reg     <= mask_next;
            status_reg   <= status_next;
            rsp_addr_reg <= rsp_addr_next;
            clr_cnt_reg  <= clr_cnt_next;
            valid_reg    <= valid_next;
            occ_reg      <= occ_next;
        end
    end
endmodule
